// File: rtl/oflow_core_write_seq_if.sv
// ---------------------------------------------------------------------------
// oflow_core_write_seq_if
// Beat bus between the core write sequencer and the MEM buffer.
//   master (sequencer): drives beat_valid, row_sel, pe_sel, lane_cnt,
//                       last_in_row, last_in_frame; samples buf_ready,
//                       buf_row_done
//   slave  (buffer)   : the mirror image
// ---------------------------------------------------------------------------
interface oflow_core_write_seq_if #(
    parameter int ROW_LEN  = 4,
    parameter int PE_LEN   = 5,
    parameter int LANE_LEN = 3
);
    logic                beat_valid;
    logic [ROW_LEN-1:0]  row_sel;
    logic [PE_LEN-1:0]   pe_sel;
    logic [LANE_LEN-1:0] lane_cnt;
    logic                last_in_row;
    logic                last_in_frame;
    logic                buf_ready;
    logic                buf_row_done;

    modport master (
        output beat_valid, row_sel, pe_sel, lane_cnt, last_in_row, last_in_frame,
        input  buf_ready, buf_row_done
    );

    modport slave (
        input  beat_valid, row_sel, pe_sel, lane_cnt, last_in_row, last_in_frame,
        output buf_ready, buf_row_done
    );
endinterface

// File: rtl/oflow_core_write_seq.sv
// ---------------------------------------------------------------------------
// oflow_core_write_seq
// Walks a frame's bboxes row by row and, inside a row, in groups of up to
// PE_GROUP processing elements, issuing one valid/ready write beat per group
// to the MEM buffer. Optionally waits for buf_row_done after each row.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start_write           start pulse (accepted only in IDLE)
//   num_of_bbox_in_frame  bbox count, latched on accepted start
//   busy                  high in LOAD / BEAT / ROW_WAIT
//   done                  one-cycle pulse at frame end
//   overflow_err          count exceeded MAX_BBOX (sticky until next start)
//   bus                   beat bus (master side), see oflow_core_write_seq_if
// All outputs are registered.
// ---------------------------------------------------------------------------
module oflow_core_write_seq #(
    parameter int PE_NUM        = 22,
    parameter int PE_GROUP      = 4,
    parameter int MAX_ROWS      = 16,
    parameter int WAIT_ROW_DONE = 1,
    parameter int NUM_W         = $clog2(MAX_ROWS*PE_NUM+1),
    parameter int ROW_LEN       = $clog2(MAX_ROWS),
    parameter int PE_LEN        = $clog2(PE_NUM),
    parameter int LANE_LEN      = $clog2(PE_GROUP+1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_write,
    input  logic [NUM_W-1:0]       num_of_bbox_in_frame,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow_err,
    oflow_core_write_seq_if.master bus
);
    localparam int MAX_BBOX = MAX_ROWS*PE_NUM;
    // Row and PE arithmetic carry one extra bit: full_rows/total_rows can
    // equal MAX_ROWS and a row length can equal PE_NUM.
    localparam int RW = ROW_LEN + 1;
    localparam int PW = PE_LEN + 1;

    localparam logic [NUM_W-1:0] MAX_BBOX_N = NUM_W'(MAX_BBOX);
    localparam logic [NUM_W-1:0] PE_NUM_N   = NUM_W'(PE_NUM);
    localparam logic [PW-1:0]    PE_NUM_P   = PW'(PE_NUM);
    localparam logic [PW-1:0]    PE_GROUP_P = PW'(PE_GROUP);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_BEAT     = 3'd2;
    localparam logic [2:0] S_ROW_WAIT = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]          state_r,      state_s;
    logic [NUM_W-1:0]    n_r,          n_s;
    logic [RW-1:0]       full_rows_r,  full_rows_s;
    logic [PW-1:0]       rem_r,        rem_s;
    logic [RW-1:0]       total_rows_r, total_rows_s;
    logic [ROW_LEN-1:0]  row_r,        row_s;
    logic [PE_LEN-1:0]   pe_r,         pe_s;
    logic [LANE_LEN-1:0] lane_r,       lane_s;
    logic                lir_r,        lir_s;
    logic                lif_r,        lif_s;
    logic                beat_valid_r, beat_valid_s;
    logic                busy_r,       busy_s;
    logic                done_r,       done_s;
    logic                overflow_r,   overflow_s;

    logic [NUM_W-1:0]    quot_s;
    logic [NUM_W-1:0]    mod_s;
    logic [PW-1:0]       k_s;
    logic [PW-1:0]       left_s;
    logic [PW-1:0]       lane_full_s;

    // Row split of the latched count; only captured into registers in LOAD.
    assign quot_s = n_r / PE_NUM_N;
    assign mod_s  = n_r % PE_NUM_N;

    // Next-state, counter and latched-count logic of the sequencer FSM.
    always_comb begin
        state_s      = state_r;
        n_s          = n_r;
        full_rows_s  = full_rows_r;
        rem_s        = rem_r;
        total_rows_s = total_rows_r;
        row_s        = row_r;
        pe_s         = pe_r;
        overflow_s   = overflow_r;
        case (state_r)
            S_IDLE: begin
                if (start_write) begin
                    state_s = S_LOAD;
                    if (num_of_bbox_in_frame > MAX_BBOX_N) begin
                        overflow_s = 1'b1;
                        n_s        = MAX_BBOX_N;
                    end else begin
                        overflow_s = 1'b0;
                        n_s        = num_of_bbox_in_frame;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                full_rows_s  = RW'(quot_s);
                rem_s        = PW'(mod_s);
                total_rows_s = RW'(quot_s) + ((mod_s != NUM_W'(0)) ? RW'(1) : RW'(0));
                row_s        = ROW_LEN'(0);
                pe_s         = PE_LEN'(0);
                if (n_r == NUM_W'(0)) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_BEAT;
                end
            end
            S_BEAT: begin
                if (buf_ready_w()) begin
                    if (!lir_r) begin
                        pe_s = PE_LEN'(PW'(pe_r) + PE_GROUP_P);
                    end else if (lif_r) begin
                        state_s = S_DONE;
                    end else if (WAIT_ROW_DONE != 0) begin
                        state_s = S_ROW_WAIT;
                    end else begin
                        row_s = row_r + ROW_LEN'(1);
                        pe_s  = PE_LEN'(0);
                    end
                end else begin
                    state_s = S_BEAT;
                end
            end
            S_ROW_WAIT: begin
                if (bus.buf_row_done) begin
                    row_s   = row_r + ROW_LEN'(1);
                    pe_s    = PE_LEN'(0);
                    state_s = S_BEAT;
                end else begin
                    state_s = S_ROW_WAIT;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    function automatic logic buf_ready_w();
        return bus.buf_ready;
    endfunction

    // Lane count and last-beat flags of the beat presented next cycle.
    always_comb begin
        // Rows before full_rows are complete; the one after holds the remainder.
        if (RW'(row_s) < full_rows_s) begin
            k_s = PE_NUM_P;
        end else begin
            k_s = rem_s;
        end
        left_s = k_s - PW'(pe_s);
        if (left_s > PE_GROUP_P) begin
            lane_full_s = PE_GROUP_P;
        end else begin
            lane_full_s = left_s;
        end
        beat_valid_s = (state_s == S_BEAT);
        busy_s       = (state_s == S_LOAD) || (state_s == S_BEAT) || (state_s == S_ROW_WAIT);
        done_s       = (state_s == S_DONE);
        if (beat_valid_s) begin
            lane_s = LANE_LEN'(lane_full_s);
            lir_s  = ((PW'(pe_s) + lane_full_s) == k_s);
            lif_s  = lir_s && (RW'(row_s) == (total_rows_s - RW'(1)));
        end else begin
            lane_s = LANE_LEN'(0);
            lir_s  = 1'b0;
            lif_s  = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            n_r          <= NUM_W'(0);
            full_rows_r  <= RW'(0);
            rem_r        <= PW'(0);
            total_rows_r <= RW'(0);
            row_r        <= ROW_LEN'(0);
            pe_r         <= PE_LEN'(0);
            lane_r       <= LANE_LEN'(0);
            lir_r        <= 1'b0;
            lif_r        <= 1'b0;
            beat_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            n_r          <= n_s;
            full_rows_r  <= full_rows_s;
            rem_r        <= rem_s;
            total_rows_r <= total_rows_s;
            row_r        <= row_s;
            pe_r         <= pe_s;
            lane_r       <= lane_s;
            lir_r        <= lir_s;
            lif_r        <= lif_s;
            beat_valid_r <= beat_valid_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            overflow_r   <= overflow_s;
        end
    end

    assign busy              = busy_r;
    assign done              = done_r;
    assign overflow_err      = overflow_r;
    assign bus.beat_valid    = beat_valid_r;
    assign bus.row_sel       = row_r;
    assign bus.pe_sel        = pe_r;
    assign bus.lane_cnt      = lane_r;
    assign bus.last_in_row   = lir_r;
    assign bus.last_in_frame = lif_r;
endmodule

// File: tb/tb_oflow_core_write_seq.sv
// ---------------------------------------------------------------------------
// tb_oflow_core_write_seq
// Two sequencers: dut_a waits for buf_row_done per row, dut_b does not.
// Stimulus pushes hand-computed beats/done events into per-DUT queues;
// negedge monitors pop and compare each accepted beat and each done pulse.
// ---------------------------------------------------------------------------
module tb_oflow_core_write_seq;
    logic       clk;
    logic       reset;
    logic       a_start, b_start;
    logic [8:0] a_num, b_num;
    logic       a_busy, a_done, a_ovf;
    logic       b_busy, b_done, b_ovf;

    int n_vec;
    int n_err;
    int qa[$];
    int qb[$];

    oflow_core_write_seq_if #(.ROW_LEN(4), .PE_LEN(5), .LANE_LEN(3)) a_if ();
    oflow_core_write_seq_if #(.ROW_LEN(4), .PE_LEN(5), .LANE_LEN(3)) b_if ();

    oflow_core_write_seq #(.WAIT_ROW_DONE(1)) dut_a (
        .clk(clk), .reset(reset), .start_write(a_start),
        .num_of_bbox_in_frame(a_num), .busy(a_busy), .done(a_done),
        .overflow_err(a_ovf), .bus(a_if.master)
    );

    oflow_core_write_seq #(.WAIT_ROW_DONE(0)) dut_b (
        .clk(clk), .reset(reset), .start_write(b_start),
        .num_of_bbox_in_frame(b_num), .busy(b_busy), .done(b_done),
        .overflow_err(b_ovf), .bus(b_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pk(int kind, int row, int pe, int lane, int lir, int lif);
        return (kind << 24) | (row << 16) | (pe << 8) | (lane << 4) | (lir << 1) | lif;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pop_cmp(input int which, input string nm, input int act);
        int exp;
        if ((which == 0 && qa.size() == 0) || (which == 1 && qb.size() == 0)) begin
            check({nm, "_unexpected"}, act, -1);
        end else begin
            exp = (which == 0) ? qa.pop_front() : qb.pop_front();
            check(nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected beats of one row; full rows use pe 0..20 with lanes 4,4,4,4,4,2.
    task automatic push_full_row(input int which, input int row, input int frame_last);
        int pes[6]   = '{0, 4, 8, 12, 16, 20};
        int lanes[6] = '{4, 4, 4, 4, 4, 2};
        for (int i = 0; i < 6; i++) begin
            if (which == 0)
                qa.push_back(pk(1, row, pes[i], lanes[i], (i == 5) ? 1 : 0, (i == 5) ? frame_last : 0));
            else
                qb.push_back(pk(1, row, pes[i], lanes[i], (i == 5) ? 1 : 0, (i == 5) ? frame_last : 0));
        end
    endtask

    // Scoreboard monitor for dut_a.
    always @(negedge clk) begin
        if (!reset) begin
            if (a_if.beat_valid && a_if.buf_ready)
                pop_cmp(0, "a_beat", pk(1, int'(a_if.row_sel), int'(a_if.pe_sel), int'(a_if.lane_cnt),
                                        int'(a_if.last_in_row), int'(a_if.last_in_frame)));
            if (a_done)
                pop_cmp(0, "a_done", pk(2, 0, 0, 0, 0, 0));
        end
    end

    // Scoreboard monitor for dut_b.
    always @(negedge clk) begin
        if (!reset) begin
            if (b_if.beat_valid && b_if.buf_ready)
                pop_cmp(1, "b_beat", pk(1, int'(b_if.row_sel), int'(b_if.pe_sel), int'(b_if.lane_cnt),
                                        int'(b_if.last_in_row), int'(b_if.last_in_frame)));
            if (b_done)
                pop_cmp(1, "b_done", pk(2, 0, 0, 0, 0, 0));
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_num = 9'd0;   b_num = 9'd0;
        a_if.buf_ready = 1'b0; a_if.buf_row_done = 1'b0;
        b_if.buf_ready = 1'b1; b_if.buf_row_done = 1'b0;
        tick(2);
        check("rst_a_busy", int'(a_busy), 0);
        check("rst_a_bv", int'(a_if.beat_valid), 0);
        check("rst_a_done", int'(a_done), 0);
        check("rst_a_ovf", int'(a_ovf), 0);
        check("rst_b_busy", int'(b_busy), 0);
        reset = 1'b0;
        tick(1);

        // Two full rows with per-row wait.
        a_if.buf_ready = 1'b1;
        push_full_row(0, 0, 0);
        push_full_row(0, 1, 1);
        qa.push_back(pk(2, 0, 0, 0, 0, 0));
        a_num = 9'd44; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        check("t1_busy_load", int'(a_busy), 1);
        check("t1_bv_load", int'(a_if.beat_valid), 0);
        tick(1);
        check("t1_first_bv", int'(a_if.beat_valid), 1);
        tick(6);
        check("t1_rowwait_bv", int'(a_if.beat_valid), 0);
        check("t1_rowwait_busy", int'(a_busy), 1);
        tick(2);
        check("t1_rowwait_bv2", int'(a_if.beat_valid), 0);
        a_if.buf_row_done = 1'b1;
        tick(1);
        a_if.buf_row_done = 1'b0;
        tick(6);
        check("t1_done", int'(a_done), 1);
        check("t1_done_busy", int'(a_busy), 0);
        tick(1);
        check("t1_done_pulse", int'(a_done), 0);

        // Partial row: 27 bboxes.
        push_full_row(0, 0, 0);
        qa.push_back(pk(1, 1, 0, 4, 0, 0));
        qa.push_back(pk(1, 1, 4, 1, 1, 1));
        qa.push_back(pk(2, 0, 0, 0, 0, 0));
        a_num = 9'd27; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        tick(7);
        check("t2_rowwait_bv", int'(a_if.beat_valid), 0);
        a_if.buf_row_done = 1'b1;
        tick(1);
        a_if.buf_row_done = 1'b0;
        tick(2);
        check("t2_done", int'(a_done), 1);
        tick(1);

        // Zero count: no beat, done two cycles after start.
        qa.push_back(pk(2, 0, 0, 0, 0, 0));
        a_num = 9'd0; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        check("t3_zero_bv", int'(a_if.beat_valid), 0);
        tick(1);
        check("t3_zero_done", int'(a_done), 1);
        check("t3_zero_bv2", int'(a_if.beat_valid), 0);
        tick(1);

        // Three bboxes: single beat with both flags.
        qa.push_back(pk(1, 0, 0, 3, 1, 1));
        qa.push_back(pk(2, 0, 0, 0, 0, 0));
        a_num = 9'd3; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        tick(1);
        check("t3_three_bv", int'(a_if.beat_valid), 1);
        tick(1);
        check("t3_three_done", int'(a_done), 1);
        tick(1);

        // Backpressure with an ignored mid-frame start.
        a_if.buf_ready = 1'b0;
        qa.push_back(pk(1, 0, 0, 4, 0, 0));
        qa.push_back(pk(1, 0, 4, 4, 1, 1));
        qa.push_back(pk(2, 0, 0, 0, 0, 0));
        a_num = 9'd8; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_bv", int'(a_if.beat_valid), 1);
            check("t4_hold_pe", int'(a_if.pe_sel), 0);
            check("t4_hold_lane", int'(a_if.lane_cnt), 4);
            check("t4_hold_row", int'(a_if.row_sel), 0);
            a_start = (i == 2) ? 1'b1 : 1'b0;
            a_num   = 9'd44;
            tick(1);
        end
        a_start = 1'b0;
        a_if.buf_ready = 1'b1;
        tick(1);
        check("t4_beat1_pe", int'(a_if.pe_sel), 4);
        check("t4_beat1_lane", int'(a_if.lane_cnt), 4);
        tick(1);
        check("t4_done", int'(a_done), 1);
        tick(1);
        check("t4_idle_busy", int'(a_busy), 0);

        // No-wait mode with overflow clamped to 352.
        for (int r = 0; r < 16; r++) push_full_row(1, r, (r == 15) ? 1 : 0);
        qb.push_back(pk(2, 0, 0, 0, 0, 0));
        b_num = 9'd400; b_start = 1'b1;
        tick(1);
        b_start = 1'b0;
        check("t5_ovf", int'(b_ovf), 1);
        tick(1);
        for (int i = 0; i < 96; i++) begin
            check("t5_no_gap_bv", int'(b_if.beat_valid), 1);
            tick(1);
        end
        check("t5_done", int'(b_done), 1);
        check("t5_ovf_sticky", int'(b_ovf), 1);
        tick(1);
        check("t5_ovf_after_done", int'(b_ovf), 1);
        qb.push_back(pk(1, 0, 0, 4, 0, 0));
        qb.push_back(pk(1, 0, 4, 1, 1, 1));
        qb.push_back(pk(2, 0, 0, 0, 0, 0));
        b_num = 9'd5; b_start = 1'b1;
        tick(1);
        b_start = 1'b0;
        check("t5_ovf_cleared", int'(b_ovf), 0);
        tick(3);
        check("t5_small_done", int'(b_done), 1);
        tick(1);

        // Reset during row 1 of a 44-bbox frame.
        push_full_row(0, 0, 0);
        push_full_row(0, 1, 1);
        qa.push_back(pk(2, 0, 0, 0, 0, 0));
        a_num = 9'd44; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        tick(7);
        a_if.buf_row_done = 1'b1;
        tick(1);
        a_if.buf_row_done = 1'b0;
        tick(2);
        check("t6_mid_row_pe", int'(a_if.pe_sel), 8);
        qa.delete();
        reset = 1'b1;
        tick(1);
        check("t6_rst_bv", int'(a_if.beat_valid), 0);
        check("t6_rst_busy", int'(a_busy), 0);
        check("t6_rst_done", int'(a_done), 0);
        check("t6_rst_row", int'(a_if.row_sel), 0);
        check("t6_rst_pe", int'(a_if.pe_sel), 0);
        check("t6_rst_lane", int'(a_if.lane_cnt), 0);
        check("t6_rst_flags", int'({a_if.last_in_row, a_if.last_in_frame}), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_no_done", int'(a_done), 0);
            tick(1);
        end
        qa.push_back(pk(1, 0, 0, 4, 1, 1));
        qa.push_back(pk(2, 0, 0, 0, 0, 0));
        a_num = 9'd4; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        tick(1);
        check("t6_new_bv", int'(a_if.beat_valid), 1);
        tick(1);
        check("t6_new_done", int'(a_done), 1);
        tick(2);

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
